// File: rtl/score_display.sv
// score_display: drives a 4-digit multiplexed common-anode seven-segment display
// from the live mole-game score, level and timer.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   score     current score, binary 0..1023 (values above 999 display as 999)
//   level     current level 1..3 (0 shows a dash)
//   timer     elapsed 2-second ticks; at GAME_TICKS or more the level digit's dp lights
//   an        digit anodes, active-low one-hot, an[0] = rightmost digit
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   dp        decimal point, active-low
//   bcd_valid high while the BCD result registers match the current conversion source
module score_display #(
    parameter int unsigned SCAN_CNT   = 100000,
    parameter int unsigned GAME_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] score,
    input  logic [1:0] level,
    input  logic [6:0] timer,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       bcd_valid
);

    localparam int unsigned    CntW      = $clog2(SCAN_CNT);
    localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_CNT - 1);
    localparam logic [6:0]     GameTicks = 7'(GAME_TICKS);
    localparam logic [6:0]     SegBlank  = 7'b1111111;
    localparam logic [6:0]     SegDash   = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e          state_q, state_d;
    logic [9:0]      conv_src_q, conv_src_d;
    logic [21:0]     shift_q, shift_d;
    logic [3:0]      iter_q, iter_d;
    logic [3:0]      hund_q, hund_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic            valid_q, valid_d;
    logic [CntW-1:0] scan_q, scan_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic [9:0]      sat;
    logic [21:0]     adj;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    assign sat = (score > 10'd999) ? 10'd999 : score;

    // Double-dabble correction: nibbles >= 5 get +3 before the shift.
    always_comb begin
        adj = shift_q;
        if (shift_q[13:10] >= 4'd5) adj[13:10] = shift_q[13:10] + 4'd3;
        if (shift_q[17:14] >= 4'd5) adj[17:14] = shift_q[17:14] + 4'd3;
        if (shift_q[21:18] >= 4'd5) adj[21:18] = shift_q[21:18] + 4'd3;
    end

    always_comb begin
        state_d    = state_q;
        conv_src_d = conv_src_q;
        shift_d    = shift_q;
        iter_d     = iter_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        valid_d    = valid_q;
        case (state_q)
            StIdle: begin
                // conv_src holds the raw score so 1000..1023 changes still retrigger.
                if (score != conv_src_q) begin
                    conv_src_d = score;
                    shift_d    = {12'b0, sat};
                    iter_d     = 4'd0;
                    valid_d    = 1'b0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                shift_d = {adj[20:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd9) state_d = StLoad;
            end
            StLoad: begin
                // All three digits land in the same cycle; never a partial update.
                hund_d  = shift_q[21:18];
                tens_d  = shift_q[17:14];
                ones_d  = shift_q[13:10];
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scan_d = scan_q + CntW'(1);
        idx_d  = idx_q;
        if (scan_q == CntMax) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    always_comb begin
        an_d = ~(4'b0001 << idx_q);
        dp_d = !((idx_q == 2'd3) && (timer >= GameTicks));
        case (idx_q)
            2'd0:    seg_d = seg_of(ones_q);
            2'd1:    seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SegBlank : seg_of(tens_q);
            2'd2:    seg_d = (hund_q == 4'd0) ? SegBlank : seg_of(hund_q);
            default: seg_d = (level == 2'd0) ? SegDash : seg_of({2'b00, level});
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            conv_src_q <= 10'd0;
            shift_q    <= 22'd0;
            iter_q     <= 4'd0;
            hund_q     <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            valid_q    <= 1'b1;
            scan_q     <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= SegBlank;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            conv_src_q <= conv_src_d;
            shift_q    <= shift_d;
            iter_q     <= iter_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            valid_q    <= valid_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display with SCAN_CNT=4.
module tb_score_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    logic       clk;
    logic       rst;
    logic [9:0] score;
    logic [1:0] level;
    logic [6:0] timer;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       bcd_valid;

    int n_checks;
    int n_fail;

    score_display #(
        .SCAN_CNT  (4),
        .GAME_TICKS(60)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .level    (level),
        .timer    (timer),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .bcd_valid(bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for a fresh scan of digit idx, then checks its segments and dp.
    task automatic show_digit(input string tag, input int idx, input logic [6:0] exp_seg,
                              input logic exp_dp);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << idx);
        n = 0;
        while (an == want && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (an != want && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_an"}, 32'(an), 32'(want));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
        check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b0;
        score = 10'd0;
        level = 2'd1;
        timer = 7'd0;
        tick(3);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'(SB));
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_valid", 32'(bcd_valid), 32'd1);

        // Scan sequence from reset: each digit held 4 cycles, first update after edge 1.
        rst = 1'b1;
        tick(1);
        check("scan0_an", 32'(an), 32'hE);
        check("scan0_seg", 32'(seg), 32'(S0));
        check("scan0_dp", 32'(dp), 32'd1);
        tick(3);
        check("scan0_hold_an", 32'(an), 32'hE);
        tick(1);
        check("scan1_an", 32'(an), 32'hD);
        check("scan1_seg", 32'(seg), 32'(SB));
        tick(4);
        check("scan2_an", 32'(an), 32'hB);
        check("scan2_seg", 32'(seg), 32'(SB));
        tick(4);
        check("scan3_an", 32'(an), 32'h7);
        check("scan3_seg", 32'(seg), 32'(S1));
        check("scan3_dp", 32'(dp), 32'd1);
        tick(4);
        check("scan_wrap_an", 32'(an), 32'hE);
        check("idle_valid", 32'(bcd_valid), 32'd1);

        // 0 -> 123: valid drops after the first edge and returns on edge 12.
        score = 10'd123;
        tick(1);
        check("c123_busy_first", 32'(bcd_valid), 32'd0);
        tick(10);
        check("c123_busy_last", 32'(bcd_valid), 32'd0);
        tick(1);
        check("c123_done", 32'(bcd_valid), 32'd1);
        show_digit("d123_h", 2, S1, 1'b1);
        show_digit("d123_t", 1, S2, 1'b1);
        show_digit("d123_o", 0, S3, 1'b1);

        // Saturation.
        score = 10'd1023;
        tick(12);
        check("c1023_done", 32'(bcd_valid), 32'd1);
        show_digit("d1023_h", 2, S9, 1'b1);
        show_digit("d1023_t", 1, S9, 1'b1);
        show_digit("d1023_o", 0, S9, 1'b1);

        // Leading-zero blanking.
        score = 10'd5;
        tick(12);
        show_digit("d5_h", 2, SB, 1'b1);
        show_digit("d5_t", 1, SB, 1'b1);
        show_digit("d5_o", 0, S5, 1'b1);

        // Zero tens with non-zero hundreds stays lit.
        score = 10'd105;
        tick(12);
        show_digit("d105_h", 2, S1, 1'b1);
        show_digit("d105_t", 1, S0, 1'b1);
        show_digit("d105_o", 0, S5, 1'b1);

        // Score change mid-conversion: first run completes, then a reconversion follows.
        score = 10'd40;
        tick(4);
        score = 10'd41;
        tick(8);
        check("c40_done", 32'(bcd_valid), 32'd1);
        tick(1);
        check("c41_restart", 32'(bcd_valid), 32'd0);
        tick(10);
        check("c41_busy_last", 32'(bcd_valid), 32'd0);
        tick(1);
        check("c41_done", 32'(bcd_valid), 32'd1);
        show_digit("d41_h", 2, SB, 1'b1);
        show_digit("d41_t", 1, S4, 1'b1);
        show_digit("d41_o", 0, S1, 1'b1);

        // Level digit and game-over decimal point.
        level = 2'd2;
        timer = 7'd59;
        show_digit("lvl2_t59", 3, S2, 1'b1);
        timer = 7'd60;
        show_digit("lvl2_t60", 3, S2, 1'b0);
        show_digit("t60_d0", 0, S1, 1'b1);
        show_digit("t60_d1", 1, S4, 1'b1);
        level = 2'd0;
        show_digit("lvl0", 3, SD, 1'b0);
        level = 2'd3;
        timer = 7'd0;
        show_digit("lvl3", 3, S3, 1'b1);

        // Reset in the middle of a conversion.
        score = 10'd777;
        tick(3);
        rst = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'(SB));
        check("midrst_dp", 32'(dp), 32'd1);
        check("midrst_valid", 32'(bcd_valid), 32'd1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("post_rst_an", 32'(an), 32'hE);
        check("post_rst_seg", 32'(seg), 32'(S0));
        check("post_rst_busy", 32'(bcd_valid), 32'd0);
        tick(11);
        check("c777_done", 32'(bcd_valid), 32'd1);
        show_digit("d777_h", 2, S7, 1'b1);
        show_digit("d777_t", 1, S7, 1'b1);
        show_digit("d777_o", 0, S7, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
